// File: rtl/micro_pkg.sv
// Shared types for the microprogram sequencer: MUX C select codes,
// run/halt state encoding and the default control-address width.
package micro_pkg;

   localparam int AW_DEF = 8;

   typedef enum logic [1:0] {
      SEL_INC = 2'b00,
      SEL_BRA = 2'b01,
      SEL_RAA = 2'b10,
      SEL_RET = 2'b11
   } sel_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } state_e;

endpackage

// File: rtl/control_addr_seq_if.sv
// Sequencer control/address bundle between the microinstruction side
// (master: start/stall/halt/select/bra/raa/call) and the CAR stage
// (slave: returns car/running/wrap).
interface control_addr_seq_if
   import micro_pkg::*;
#(
   parameter int AW = AW_DEF
) ();

   logic          start;
   logic          stall;
   logic          halt;
   logic [1:0]    mux_c_sel;
   logic [AW-1:0] bra;
   logic [AW-1:0] raa;
   logic          call;
   logic [AW-1:0] car;
   logic          running;
   logic          wrap;

   modport master (
      output start, stall, halt, mux_c_sel, bra, raa, call,
      input  car, running, wrap
   );

   modport slave (
      input  start, stall, halt, mux_c_sel, bra, raa, call,
      output car, running, wrap
   );

endinterface

// File: rtl/car_next_mux.sv
// Next control address select plus incrementer.
// Ports: car/sel/bra/raa/ret in; inc_addr/inc_carry (CAR+1 and its
// carry-out), nxt_addr (selected address), nxt_wrap (increment chosen
// and it wrapped) out.
module car_next_mux
   import micro_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic [AW-1:0] car,
   input  sel_e          sel,
   input  logic [AW-1:0] bra,
   input  logic [AW-1:0] raa,
   input  logic [AW-1:0] ret,
   output logic [AW-1:0] inc_addr,
   output logic          inc_carry,
   output logic [AW-1:0] nxt_addr,
   output logic          nxt_wrap
);

   always_comb begin
      {inc_carry, inc_addr} = {1'b0, car} + (AW+1)'(1);
      nxt_addr = inc_addr;
      nxt_wrap = 1'b0;
      unique case (sel)
         SEL_INC: begin
            nxt_addr = inc_addr;
            nxt_wrap = inc_carry;
         end
         SEL_BRA: nxt_addr = bra;
         SEL_RAA: nxt_addr = raa;
         SEL_RET: nxt_addr = ret;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_addr_seq.sv
// Control address register stage with run/halt sequencer FSM.
// Ports: clk, rst_n (async active-low), bus (slave: start, stall, halt,
// mux_c_sel, bra, raa, call in; car, running, wrap out).
// Optional return register enabled by defining MICRO_RET_EN.
module control_addr_seq
   import micro_pkg::*;
#(
   parameter int            AW        = AW_DEF,
   parameter logic [AW-1:0] RESET_VEC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   control_addr_seq_if.slave bus
);

   state_e        state_q, state_d;
   logic [AW-1:0] car_q, car_d;
   logic          wrap_q, wrap_d;
   logic          running_q, running_d;

   logic [AW-1:0] ret_q;
   sel_e          sel_eff;
   logic [AW-1:0] inc_addr, nxt_addr;
   logic          inc_carry, nxt_wrap;
   logic          advance;

   // RUN, not stalled, not halting: CAR takes the selected address
   assign advance = (state_q == ST_RUN) & ~bus.stall & ~bus.halt;

`ifdef MICRO_RET_EN
   logic [AW-1:0] ret_d;

   assign sel_eff = sel_e'(bus.mux_c_sel);

   always_comb begin
      ret_d = ret_q;
      if (advance && bus.call && sel_eff == SEL_BRA)
         ret_d = inc_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ret_q <= '0;
      else
         ret_q <= ret_d;
   end
`else
   logic unused_call;

   // RET folds onto the increment path, wrap rule included
   assign sel_eff = (bus.mux_c_sel == SEL_RET) ? SEL_INC
                                               : sel_e'(bus.mux_c_sel);
   assign ret_q = '0;
   assign unused_call = bus.call;
`endif

   car_next_mux #(
      .AW (AW)
   ) u_next (
      .car       (car_q),
      .sel       (sel_eff),
      .bra       (bus.bra),
      .raa       (bus.raa),
      .ret       (ret_q),
      .inc_addr  (inc_addr),
      .inc_carry (inc_carry),
      .nxt_addr  (nxt_addr),
      .nxt_wrap  (nxt_wrap)
   );

   always_comb begin
      state_d = state_q;
      car_d   = car_q;
      wrap_d  = wrap_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.stall) begin
               state_d = ST_RUN;
            end else if (bus.halt) begin
               state_d = ST_HALTED;
            end else begin
               car_d  = nxt_addr;
               wrap_d = wrap_q | nxt_wrap;
            end
         end
         ST_HALTED: begin
            // resume past the halting microinstruction
            if (bus.start) begin
               state_d = ST_RUN;
               car_d   = inc_addr;
               wrap_d  = wrap_q | inc_carry;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         car_q     <= RESET_VEC;
         wrap_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         car_q     <= car_d;
         wrap_q    <= wrap_d;
         running_q <= running_d;
      end
   end

   assign bus.car     = car_q;
   assign bus.running = running_q;
   assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_control_addr_seq.sv
// Randomized and directed bench for control_addr_seq against a
// behavioural sequencer model; honours MICRO_RET_EN like the design.
module tb_control_addr_seq;

   localparam int AW = 8;
   localparam int MOD = 256;

   logic clk;
   logic rst_n;

   control_addr_seq_if #(.AW(AW)) bus ();

   control_addr_seq #(
      .AW        (AW),
      .RESET_VEC (8'h00)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // model: ms 0=idle 1=run 2=halted
   int ms;
   int mcar;
   int mret;
   bit mwrap;

`ifdef MICRO_RET_EN
   localparam bit RET = 1'b1;
`else
   localparam bit RET = 1'b0;
`endif

   task automatic model_reset();
      ms = 0;
      mcar = 0;
      mret = 0;
      mwrap = 1'b0;
   endtask

   task automatic model_inc();
      if (mcar == MOD - 1) begin
         mcar = 0;
         mwrap = 1'b1;
      end else begin
         mcar = mcar + 1;
      end
   endtask

   task automatic model_step();
      if (ms == 0) begin
         if (bus.start) ms = 1;
      end else if (ms == 1) begin
         if (bus.stall) begin
         end else if (bus.halt) begin
            ms = 2;
         end else begin
            case (bus.mux_c_sel)
               2'd0: model_inc();
               2'd1: begin
                  if (RET && bus.call) mret = (mcar + 1) % MOD;
                  mcar = int'(bus.bra);
               end
               2'd2: mcar = int'(bus.raa);
               default: begin
                  if (RET) mcar = mret;
                  else model_inc();
               end
            endcase
         end
      end else begin
         if (bus.start) begin
            ms = 1;
            model_inc();
         end
      end
   endtask

   task automatic drive(input bit st, input bit sl, input bit hl,
                        input logic [1:0] sel, input logic [7:0] b,
                        input logic [7:0] r, input bit c);
      bus.start = st;
      bus.stall = sl;
      bus.halt = hl;
      bus.mux_c_sel = sel;
      bus.bra = b;
      bus.raa = r;
      bus.call = c;
   endtask

   task automatic idle_in();
      drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
   endtask

   // advance one edge: model samples the same inputs, then settle
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_in();
      model_reset();
      repeat (2) @(negedge clk);
      total_cnt++;
      if (bus.car !== 8'h00)
         $display("FAIL reset_car got %h want 00", bus.car);
      else pass_cnt++;
      total_cnt++;
      if (bus.running !== 1'b0)
         $display("FAIL reset_running got %b want 0", bus.running);
      else pass_cnt++;
      total_cnt++;
      if (bus.wrap !== 1'b0)
         $display("FAIL reset_wrap got %b want 0", bus.wrap);
      else pass_cnt++;
      rst_n = 1'b1;
      cyc();
      total_cnt++;
      if (bus.running !== 1'b0)
         $display("FAIL idle_no_start got %b want 0", bus.running);
      else pass_cnt++;
   endtask

   task automatic test_start_inc();
      logic [7:0] want;
      drive(1, 0, 0, 2'd2, 8'h77, 8'h66, 0);
      cyc();
      idle_in();
      total_cnt++;
      if (bus.car !== 8'h00 || bus.running !== 1'b1)
         $display("FAIL start car %h run %b want 00 1",
                  bus.car, bus.running);
      else pass_cnt++;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         want = 8'(i);
         total_cnt++;
         if (bus.car !== want || bus.running !== 1'b1 ||
             int'(bus.car) != mcar)
            $display("FAIL inc_%0d car %h run %b want %h 1",
                     i, bus.car, bus.running, want);
         else pass_cnt++;
      end
   endtask

   task automatic test_branch();
      drive(0, 0, 0, 2'd1, 8'h40, 8'h00, 0);
      cyc();
      total_cnt++;
      if (bus.car !== 8'h40)
         $display("FAIL bra got %h want 40", bus.car);
      else pass_cnt++;
      drive(0, 0, 0, 2'd2, 8'h00, 8'h1C, 0);
      cyc();
      total_cnt++;
      if (bus.car !== 8'h1C)
         $display("FAIL raa got %h want 1c", bus.car);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      drive(0, 0, 0, 2'd1, 8'hFF, 8'h00, 0);
      cyc();
      drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
      cyc();
      total_cnt++;
      if (bus.car !== 8'h00 || bus.wrap !== 1'b1)
         $display("FAIL wrap car %h wrap %b want 00 1",
                  bus.car, bus.wrap);
      else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 2'd1, 8'($urandom_range(0, 200)), 8'h00, 0);
         cyc();
      end
      idle_in();
      total_cnt++;
      if (bus.wrap !== 1'b1)
         $display("FAIL wrap_sticky got %b want 1", bus.wrap);
      else pass_cnt++;
   endtask

   task automatic test_stall_halt();
      drive(0, 0, 0, 2'd1, 8'h12, 8'h00, 0);
      cyc();
      drive(0, 1, 1, 2'd1, 8'h99, 8'h00, 1);
      cyc();
      total_cnt++;
      if (bus.car !== 8'h12 || bus.running !== 1'b1)
         $display("FAIL stall_halt car %h run %b want 12 1",
                  bus.car, bus.running);
      else pass_cnt++;
      drive(0, 0, 1, 2'd2, 8'h00, 8'h33, 0);
      cyc();
      total_cnt++;
      if (bus.car !== 8'h12 || bus.running !== 1'b0)
         $display("FAIL halt car %h run %b want 12 0",
                  bus.car, bus.running);
      else pass_cnt++;
      drive(0, 1, 0, 2'd1, 8'h44, 8'h00, 0);
      cyc();
      total_cnt++;
      if (bus.car !== 8'h12 || bus.running !== 1'b0)
         $display("FAIL halted_hold car %h run %b want 12 0",
                  bus.car, bus.running);
      else pass_cnt++;
      drive(1, 1, 0, 2'd1, 8'h44, 8'h00, 0);
      cyc();
      idle_in();
      total_cnt++;
      if (bus.car !== 8'h13 || bus.running !== 1'b1)
         $display("FAIL resume car %h run %b want 13 1",
                  bus.car, bus.running);
      else pass_cnt++;
   endtask

   task automatic test_call_ret();
      logic [7:0] want;
      drive(0, 0, 0, 2'd1, 8'h20, 8'h00, 0);
      cyc();
      drive(0, 0, 0, 2'd1, 8'h80, 8'h00, 1);
      cyc();
      total_cnt++;
      if (bus.car !== 8'h80)
         $display("FAIL call got %h want 80", bus.car);
      else pass_cnt++;
      drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 0);
      cyc();
      cyc();
      drive(0, 0, 0, 2'd3, 8'h00, 8'h00, 0);
      cyc();
      idle_in();
      want = RET ? 8'h21 : 8'h83;
      total_cnt++;
      if (bus.car !== want)
         $display("FAIL ret got %h want %h", bus.car, want);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 9) == 0),
               ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 9) == 0),
               2'($urandom_range(0, 3)),
               8'($urandom), 8'($urandom),
               $urandom_range(0, 1) == 1);
         cyc();
         total_cnt++;
         if (int'(bus.car) != mcar ||
             bus.running !== (ms == 1) ||
             bus.wrap !== mwrap) begin
            errs++;
            if (errs < 10)
               $display("FAIL rand_%0d car %h run %b wrap %b want %h %b %b",
                        i, bus.car, bus.running, bus.wrap,
                        8'(mcar), (ms == 1), mwrap);
         end else pass_cnt++;
      end
      idle_in();
   endtask

   task automatic test_async_reset();
      if (ms != 1) begin
         drive(1, 0, 0, 2'd0, 8'h00, 8'h00, 0);
         cyc();
      end
      drive(0, 0, 0, 2'd1, 8'h55, 8'h00, 0);
      cyc();
      drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 1);
      total_cnt++;
      if (bus.car !== 8'h55 || bus.running !== 1'b1)
         $display("FAIL pre_reset car %h run %b want 55 1",
                  bus.car, bus.running);
      else pass_cnt++;
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      total_cnt++;
      if (bus.car !== 8'h00 || bus.running !== 1'b0 ||
          bus.wrap !== 1'b0)
         $display("FAIL async_reset car %h run %b wrap %b want 00 0 0",
                  bus.car, bus.running, bus.wrap);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      idle_in();
      cyc();
      total_cnt++;
      if (bus.car !== 8'h00 || bus.running !== 1'b0)
         $display("FAIL post_reset car %h run %b want 00 0",
                  bus.car, bus.running);
      else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_in();
      test_reset();
      test_start_inc();
      test_branch();
      test_wrap();
      test_stall_halt();
      test_call_ret();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
